vga_pattern_sequencer: RTL and testbench

- Frame-synchronous controller that selects which test pattern feeds the VGA sync/porch stage.
- Pattern changes on a manual request pulse or automatically after a programmable frame count.
- Changes take effect only at a frame boundary (vsync assertion edge), followed by a short forced-blank interval to hide the switch.
- Sits between the sync generator (supplies vsync) and the pattern generator mux (consumes o_pattern / o_blank).

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_edge_detect.sv | 28 ++
 rtl/vga_pattern_sequencer.sv | 146 ++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: sequencer state, default pattern
// sequencing constants and 640x480 timing constants.
package vga_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } seq_state_t;

    localparam int NUM_PATTERNS_DEF = 6;
    localparam int AUTO_FRAMES_DEF  = 120;
    localparam int BLANK_FRAMES_DEF = 2;

    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;

endpackage

// File: rtl/vga_edge_detect.sv
// Registered assertion-edge detector for sync signals.
// ACTIVE_LOW selects which level counts as asserted.
module vga_edge_detect #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_edge
);

    logic cur;
    logic prev;

    assign cur = (ACTIVE_LOW != 0) ? ~i_sig : i_sig;

    // Previous asserted-level sample; reset to deasserted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev <= 1'b0;
        end else begin
            prev <= cur;
        end
    end

    assign o_edge = cur & ~prev;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test pattern selector with forced blanking.
// Define VGA_SEQ_REVERSE_EN to add i_prev_req (step backwards).
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int NUM_PATTERNS     = NUM_PATTERNS_DEF,
    parameter int PAT_WIDTH        = 4,
    parameter int AUTO_FRAMES      = AUTO_FRAMES_DEF,
    parameter int BLANK_FRAMES     = BLANK_FRAMES_DEF,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vsync,
    input  logic                 i_next_req,
`ifdef VGA_SEQ_REVERSE_EN
    input  logic                 i_prev_req,
`endif
    input  logic                 i_auto_en,
    output logic [PAT_WIDTH-1:0] o_pattern,
    output logic                 o_blank,
    output logic                 o_switch_ack,
    output logic                 o_frame_tick
);

    localparam logic [PAT_WIDTH-1:0] LAST_PAT =
        PAT_WIDTH'(NUM_PATTERNS - 1);
    localparam logic [15:0] AUTO_LAST  = 16'(AUTO_FRAMES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_FRAMES - 1);

    seq_state_t     state;
    logic           frame_start;
    logic [15:0]    frame_cnt;
    logic [15:0]    blank_cnt;
    logic           pending;
    logic           expiry;
    logic           next_in;
    logic           pend_nxt;
    logic           dir_nxt;
    logic           do_switch;
    logic [PAT_WIDTH-1:0] pat_nxt;
`ifdef VGA_SEQ_REVERSE_EN
    logic           pending_dir;
`endif

    vga_edge_detect #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_vsync),
        .o_edge (frame_start)
    );

    // Merge requests into the pending flag and decide the switch
    always_comb begin
        expiry = (state == RUN) && frame_start && i_auto_en
                 && (frame_cnt == AUTO_LAST);
        next_in = i_next_req | expiry;
`ifdef VGA_SEQ_REVERSE_EN
        pend_nxt = pending;
        dir_nxt  = pending_dir;
        if (next_in && i_prev_req) begin
            pend_nxt = 1'b0;
        end else if (next_in) begin
            if (pending && pending_dir) begin
                pend_nxt = 1'b0;
            end else begin
                pend_nxt = 1'b1;
                dir_nxt  = 1'b0;
            end
        end else if (i_prev_req) begin
            if (pending && !pending_dir) begin
                pend_nxt = 1'b0;
            end else begin
                pend_nxt = 1'b1;
                dir_nxt  = 1'b1;
            end
        end
`else
        pend_nxt = pending | next_in;
        dir_nxt  = 1'b0;
`endif
        do_switch = (state == RUN) && frame_start && pend_nxt;
        if (dir_nxt) begin
            pat_nxt = (o_pattern == '0) ? LAST_PAT
                                        : o_pattern - 1'b1;
        end else begin
            pat_nxt = (o_pattern == LAST_PAT) ? '0
                                              : o_pattern + 1'b1;
        end
    end

    // Sequencer FSM, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= RUN;
            o_pattern    <= '0;
            o_blank      <= 1'b0;
            o_switch_ack <= 1'b0;
            o_frame_tick <= 1'b0;
            frame_cnt    <= '0;
            blank_cnt    <= '0;
            pending      <= 1'b0;
`ifdef VGA_SEQ_REVERSE_EN
            pending_dir  <= 1'b0;
`endif
        end else begin
            o_frame_tick <= frame_start;
            o_switch_ack <= do_switch;
            pending      <= do_switch ? 1'b0 : pend_nxt;
`ifdef VGA_SEQ_REVERSE_EN
            pending_dir  <= dir_nxt;
`endif
            if (!i_auto_en || do_switch || expiry) begin
                frame_cnt <= '0;
            end else if ((state == RUN) && frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            unique case (state)
                RUN: begin
                    if (do_switch) begin
                        o_pattern <= pat_nxt;
                        if (BLANK_FRAMES > 0) begin
                            state     <= BLANK;
                            o_blank   <= 1'b1;
                            blank_cnt <= '0;
                        end
                    end
                end
                BLANK: begin
                    if (frame_start) begin
                        if (blank_cnt == BLANK_LAST) begin
                            state   <= RUN;
                            o_blank <= 1'b0;
                        end else begin
                            blank_cnt <= blank_cnt + 16'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench: two sequencers (blanking 2 and 0 frames)
// against a frame-level reference model, plus directed tables.
module tb_vga_pattern_sequencer;

    localparam int NP = 6;
    localparam int AF = 3;

    logic clk = 1'b0;
    logic rst;
    logic vs;
    logic nreq;
    logic auto_en;
`ifdef VGA_SEQ_REVERSE_EN
    logic preq;
`endif

    logic [3:0] pat_a;
    logic       blank_a;
    logic       ack_a;
    logic       tick_a;
    logic [3:0] pat_b;
    logic       blank_b;
    logic       ack_b;
    logic       tick_b;

    always #20 clk = ~clk;

    vga_pattern_sequencer #(
        .AUTO_FRAMES  (AF),
        .BLANK_FRAMES (2)
    ) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vsync      (vs),
        .i_next_req   (nreq),
`ifdef VGA_SEQ_REVERSE_EN
        .i_prev_req   (preq),
`endif
        .i_auto_en    (auto_en),
        .o_pattern    (pat_a),
        .o_blank      (blank_a),
        .o_switch_ack (ack_a),
        .o_frame_tick (tick_a)
    );

    vga_pattern_sequencer #(
        .AUTO_FRAMES  (AF),
        .BLANK_FRAMES (0)
    ) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vsync      (vs),
        .i_next_req   (nreq),
`ifdef VGA_SEQ_REVERSE_EN
        .i_prev_req   (preq),
`endif
        .i_auto_en    (auto_en),
        .o_pattern    (pat_b),
        .o_blank      (blank_b),
        .o_switch_ack (ack_b),
        .o_frame_tick (tick_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one slot per DUT (0: blank 2, 1: blank 0)
    int m_bf[2] = '{2, 0};
    int m_pat[2];
    int m_left[2];
    int m_cnt[2];
    bit m_pend[2];
    bit m_prev[2];
    bit m_tick[2];
    bit m_ack[2];
    bit model_on = 1'b1;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares < 40)
                $display("FAIL %s: got %0d, want %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit start;
        bit expire;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pat[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
                m_pend[k] = 0; m_prev[k] = 1;
                m_tick[k] = 0; m_ack[k] = 0;
            end else begin
                start = m_prev[k] && !vs;
                m_prev[k] = vs;
                m_tick[k] = start;
                m_ack[k] = 0;
                if (!auto_en) m_cnt[k] = 0;
                if (start && m_left[k] > 0) begin
                    m_left[k]--;
                    m_pend[k] |= nreq;
                end else if (start) begin
                    expire = 0;
                    if (auto_en) begin
                        m_cnt[k]++;
                        expire = (m_cnt[k] == AF);
                    end
                    if (m_pend[k] || nreq || expire) begin
                        m_pat[k] = (m_pat[k] + 1) % NP;
                        m_ack[k] = 1;
                        m_cnt[k] = 0;
                        m_pend[k] = 0;
                        m_left[k] = m_bf[k];
                    end
                end else begin
                    m_pend[k] |= nreq;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (model_on) model_step();
        #1;
        if (model_on) begin
            check("pat_a", pat_a, m_pat[0]);
            check("blank_a", blank_a, m_left[0] > 0);
            check("ack_a", ack_a, m_ack[0]);
            check("tick_a", tick_a, m_tick[0]);
            check("pat_b", pat_b, m_pat[1]);
            check("blank_b", blank_b, m_left[1] > 0);
            check("ack_b", ack_b, m_ack[1]);
            check("tick_b", tick_b, m_tick[1]);
        end
    endtask

    task automatic frame(int len, int r0 = -1, int r1 = -1);
        for (int c = 0; c < len; c++) begin
            vs = (c < 3) ? 1'b0 : 1'b1;
            nreq = (c == r0) || (c == r1);
            cycle();
        end
        nreq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vs = 1'b1;
        nreq = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit rst;
        bit vs;
        bit nr;
        int pat;
        bit blank;
        bit ack;
        bit tick;
    } vec_t;

    vec_t tbl[14];

    initial begin
        rst = 1'b1;
        vs = 1'b1;
        nreq = 1'b0;
        auto_en = 1'b0;
`ifdef VGA_SEQ_REVERSE_EN
        preq = 1'b0;
`endif
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 1, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 1, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 1};
        tbl[12] = '{0, 1, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 2, 1, 1, 1};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            vs = tbl[i].vs;
            nreq = tbl[i].nr;
            cycle();
            check($sformatf("tbl%0d_pat", i), pat_a, tbl[i].pat);
            check($sformatf("tbl%0d_blank", i), blank_a,
                  tbl[i].blank);
            check($sformatf("tbl%0d_ack", i), ack_a, tbl[i].ack);
            check($sformatf("tbl%0d_tick", i), tick_a, tbl[i].tick);
        end
        rst = 1'b0;
        nreq = 1'b0;
        vs = 1'b1;
        cycle();

        // Three requests in one frame collapse to one advance
        do_reset();
        frame(30, 5, 10);
        nreq = 1'b1;
        cycle();
        nreq = 1'b0;
        frame(30);
        frame(30);
        frame(30);
        check("three_req_a", pat_a, 1);
        check("three_req_b", pat_b, 1);
        check("three_req_blank", blank_a, 0);

        // Walk to the last pattern, then wrap to 0
        for (int i = 0; i < 4; i++) begin
            frame(20, 5);
            frame(20);
            frame(20);
        end
        check("last_pat_a", pat_a, 5);
        frame(20, 5);
        frame(20);
        frame(20);
        check("wrap_a", pat_a, 0);
        check("wrap_b", pat_b, 0);

        // Auto advance every 3rd tick; request on expiry tick
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 9; i++) frame(20);
        check("auto_b", pat_b, 3);
        frame(20);
        frame(20);
        frame(20, 0);
        check("auto_req_b", pat_b, 4);
        auto_en = 1'b0;

        // Reset while blanking with a request pending
        do_reset();
        frame(20, 5);
        frame(20, 8);
        check("blank_pend", blank_a, 1);
        do_reset();
        check("rst_pat", pat_a, 0);
        check("rst_blank", blank_a, 0);
        check("rst_ack", ack_a, 0);
        check("rst_tick", tick_a, 0);
        for (int i = 0; i < 4; i++) frame(20);
        check("rst_no_switch", pat_a, 0);

`ifdef VGA_SEQ_REVERSE_EN
        model_on = 1'b0;
        do_reset();
        frame(20);
        preq = 1'b1;
        cycle();
        preq = 1'b0;
        frame(20);
        check("rev_wrap", pat_b, 5);
        nreq = 1'b1;
        preq = 1'b1;
        cycle();
        nreq = 1'b0;
        preq = 1'b0;
        frame(20);
        frame(20);
        check("rev_cancel", pat_b, 5);
        model_on = 1'b1;
        do_reset();
`endif

        // Randomized frames against the reference model
        for (int f = 0; f < 160; f++) begin
            int len;
            int r0;
            int r1;
            len = $urandom_range(40, 12);
            r0 = ($urandom_range(2, 0) == 0) ? -1
                 : $urandom_range(len - 1, 0);
            r1 = ($urandom_range(4, 0) == 0)
                 ? $urandom_range(len - 1, 0) : -1;
            if ($urandom_range(3, 0) == 0) auto_en = ~auto_en;
            if ($urandom_range(49, 0) == 0) do_reset();
            frame(len, r0, r1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
